// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative 64-bit multiply/divide unit (shift-add multiply, restoring divide)
module mdu_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [3:0]  mduop,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [63:0] result,
    output logic        busy
);

    localparam logic [3:0] OP_MUL   = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_REM   = 4'd4;
    localparam logic [3:0] OP_REMU  = 4'd5;
    localparam logic [3:0] OP_MULW  = 4'd6;
    localparam logic [3:0] OP_DIVW  = 4'd7;
    localparam logic [3:0] OP_DIVUW = 4'd8;
    localparam logic [3:0] OP_REMW  = 4'd9;
    localparam logic [3:0] OP_REMUW = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [6:0]  cnt;
    // Multiply: acc = partial product, x = shifted multiplicand, y = shifted multiplier.
    // Divide:   acc = partial remainder, x = dividend/quotient shift register, y = divisor magnitude.
    logic [63:0] acc;
    logic [63:0] x;
    logic [63:0] y;
    logic        op_mul;
    logic        op_w;
    logic        op_rem;
    logic        neg_q;
    logic        neg_r;

    // Request decode, operand conditioning and special-case results at accept time
    logic        is_mul_in;
    logic        is_div_in;
    logic        is_w_in;
    logic        is_rem_in;
    logic        is_sgn_in;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] a_sx_w;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] mag_a;
    logic [63:0] mag_b;
    logic        b_zero;
    logic        ovf;
    logic        special;
    logic [63:0] special_res;
    logic [63:0] x_init;
    logic [63:0] y_init;

    // Decode the incoming request and pre-compute everything latched on accept
    always_comb begin
        is_mul_in   = (mduop == OP_MUL) || (mduop == OP_MULW);
        is_div_in   = (mduop == OP_DIV)  || (mduop == OP_DIVU)  || (mduop == OP_REM)  ||
                      (mduop == OP_REMU) || (mduop == OP_DIVW)  || (mduop == OP_DIVUW) ||
                      (mduop == OP_REMW) || (mduop == OP_REMUW);
        is_w_in     = (mduop == OP_MULW) || (mduop == OP_DIVW) || (mduop == OP_DIVUW) ||
                      (mduop == OP_REMW) || (mduop == OP_REMUW);
        is_rem_in   = (mduop == OP_REM)  || (mduop == OP_REMU) || (mduop == OP_REMW) ||
                      (mduop == OP_REMUW);
        is_sgn_in   = (mduop == OP_DIV)  || (mduop == OP_REM)  || (mduop == OP_DIVW) ||
                      (mduop == OP_REMW);
        a_sx_w      = {{32{a[31]}}, a[31:0]};
        if (is_w_in) begin
            a_ext = is_sgn_in ? a_sx_w : {32'd0, a[31:0]};
            b_ext = is_sgn_in ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end else begin
            a_ext = a;
            b_ext = b;
        end
        neg_a       = is_sgn_in & a_ext[63];
        neg_b       = is_sgn_in & b_ext[63];
        mag_a       = neg_a ? (64'd0 - a_ext) : a_ext;
        mag_b       = neg_b ? (64'd0 - b_ext) : b_ext;
        b_zero      = (b_ext == 64'd0);
        ovf         = is_sgn_in && (b_ext == {64{1'b1}}) &&
                      (is_w_in ? (a[31:0] == 32'h8000_0000) : (a == 64'h8000_0000_0000_0000));
        special     = 1'b0;
        special_res = 64'd0;
        if (!is_mul_in && !is_div_in) begin
            special = 1'b1;
        end else if (is_div_in && b_zero) begin
            special     = 1'b1;
            special_res = is_rem_in ? (is_w_in ? a_sx_w : a) : {64{1'b1}};
        end else if (is_div_in && ovf) begin
            special     = 1'b1;
            special_res = is_rem_in ? 64'd0 : (is_w_in ? a_sx_w : a);
        end
        // W divides park the 32-bit dividend in the top half so 32 steps consume exactly its bits.
        if (is_mul_in) begin
            x_init = is_w_in ? {32'd0, a[31:0]} : a;
            y_init = is_w_in ? {32'd0, b[31:0]} : b;
        end else begin
            x_init = is_w_in ? {mag_a[31:0], 32'd0} : mag_a;
            y_init = mag_b;
        end
    end

    // One multiply or divide step from the current iteration registers
    logic [63:0] acc_nx;
    logic [63:0] x_nx;
    logic [63:0] y_nx;
    logic [64:0] rem_sh;
    logic [64:0] diff;

    // Single shift-add / restoring shift-subtract iteration
    always_comb begin
        rem_sh = {acc, x[63]};
        diff   = rem_sh - {1'b0, y};
        if (op_mul) begin
            acc_nx = acc + (y[0] ? x : 64'd0);
            x_nx   = {x[62:0], 1'b0};
            y_nx   = {1'b0, y[63:1]};
        end else if (!diff[64]) begin
            acc_nx = diff[63:0];
            x_nx   = {x[62:0], 1'b1};
            y_nx   = y;
        end else begin
            acc_nx = rem_sh[63:0];
            x_nx   = {x[62:0], 1'b0};
            y_nx   = y;
        end
    end

    logic [63:0] q_raw;
    logic [63:0] q_s;
    logic [63:0] r_s;
    logic [63:0] sel;
    logic [63:0] fin;

    // Sign correction and width selection applied on the final iteration
    always_comb begin
        q_raw = op_w ? {32'd0, x_nx[31:0]} : x_nx;
        q_s   = neg_q ? (64'd0 - q_raw) : q_raw;
        r_s   = neg_r ? (64'd0 - acc_nx) : acc_nx;
        sel   = op_mul ? acc_nx : (op_rem ? r_s : q_s);
        fin   = op_w ? {{32{sel[31]}}, sel[31:0]} : sel;
    end

    // Control FSM plus iteration and result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= 7'd0;
            acc    <= 64'd0;
            x      <= 64'd0;
            y      <= 64'd0;
            op_mul <= 1'b0;
            op_w   <= 1'b0;
            op_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= 64'd0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= 7'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        op_mul <= is_mul_in;
                        op_w   <= is_w_in;
                        op_rem <= is_rem_in;
                        neg_q  <= neg_a ^ neg_b;
                        neg_r  <= neg_a;
                        if (special) begin
                            result <= special_res;
                            state  <= S_DONE;
                        end else begin
                            acc   <= 64'd0;
                            x     <= x_init;
                            y     <= y_init;
                            cnt   <= is_w_in ? 7'd32 : 7'd64;
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc <= acc_nx;
                    x   <= x_nx;
                    y   <= y_nx;
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        result <= fin;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_out) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready_in  = (state == S_IDLE);
    assign valid_out = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized and directed self-checking bench for mdu_iter
module tb_mdu_iter;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        valid_in;
    logic        ready_in;
    logic [3:0]  mduop;
    logic [63:0] a;
    logic [63:0] b;
    logic        valid_out;
    logic        ready_out;
    logic [63:0] result;
    logic        busy;

    int tests_run;
    int tests_failed;

    mdu_iter dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .mduop     (mduop),
        .a         (a),
        .b         (b),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural reference using native arithmetic
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] ra, input logic [63:0] rb);
        longint      sa;
        longint      sb;
        int          sa32;
        int          sb32;
        logic [31:0] ua32;
        logic [31:0] ub32;
        logic [31:0] t;
        sa   = ra;
        sb   = rb;
        ua32 = ra[31:0];
        ub32 = rb[31:0];
        sa32 = ua32;
        sb32 = ub32;
        case (op)
            4'd1: return ra * rb;
            4'd6: begin t = ua32 * ub32; return sx32(t); end
            4'd2: begin
                if (rb == 0) return ONES;
                if (ra == MIN64 && rb == ONES) return ra;
                return sa / sb;
            end
            4'd3: begin if (rb == 0) return ONES; return ra / rb; end
            4'd4: begin
                if (rb == 0) return ra;
                if (ra == MIN64 && rb == ONES) return 64'd0;
                return sa % sb;
            end
            4'd5: begin if (rb == 0) return ra; return ra % rb; end
            4'd7: begin
                if (ub32 == 0) return ONES;
                if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) return 64'hFFFF_FFFF_8000_0000;
                t = 32'(sa32 / sb32); return sx32(t);
            end
            4'd8: begin if (ub32 == 0) return ONES; t = ua32 / ub32; return sx32(t); end
            4'd9: begin
                if (ub32 == 0) return sx32(ua32);
                if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) return 64'd0;
                t = 32'(sa32 % sb32); return sx32(t);
            end
            4'd10: begin if (ub32 == 0) return sx32(ua32); t = ua32 % ub32; return sx32(t); end
            default: return 64'd0;
        endcase
    endfunction

    // Edges after the accept edge until valid_out is seen (0 = next cycle)
    function automatic int ref_latency(input logic [3:0] op, input logic [63:0] ra, input logic [63:0] rb);
        bit w;
        bit sgn;
        w   = (op >= 4'd6 && op <= 4'd10);
        sgn = (op == 4'd2 || op == 4'd4 || op == 4'd7 || op == 4'd9);
        if (op == 4'd0 || op > 4'd10) return 0;
        if (op == 4'd1 || op == 4'd6) return w ? 32 : 64;
        if (w) begin
            if (rb[31:0] == 0) return 0;
            if (sgn && ra[31:0] == 32'h8000_0000 && rb[31:0] == 32'hFFFF_FFFF) return 0;
            return 32;
        end
        if (rb == 0) return 0;
        if (sgn && ra == MIN64 && rb == ONES) return 0;
        return 64;
    endfunction

    // Issue one request, scramble inputs after accept, wait for and consume the result
    task automatic do_op(input logic [3:0] op, input logic [63:0] oa, input logic [63:0] ob,
                         output int lat, output logic [63:0] res, output bit to);
        @(negedge clk);
        mduop    = op;
        a        = oa;
        b        = ob;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        mduop    = 4'($urandom);
        lat      = 0;
        to       = 1'b0;
        while (!valid_out && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!valid_out) to = 1'b1;
        res       = result;
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        ready_out = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (ready_in !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_in: got %b expected 1", ready_in); end
        tests_run++;
        if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (result !== 64'd0) begin tests_failed++; $display("FAIL reset_result: got %h expected 0", result); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0]  ops  [8] = '{4'd1, 4'd7, 4'd9, 4'd3, 4'd5, 4'd2, 4'd4, 4'd6};
        logic [63:0] va   [8] = '{ONES, 64'h0000_0000_FFFF_FFF9, 64'h0000_0000_FFFF_FFF9, 64'd100, 64'd100,
                                  MIN64, MIN64, 64'h1234_5678_0000_FFFF};
        logic [63:0] vb   [8] = '{64'd2, 64'd2, 64'd2, 64'd0, 64'd0, ONES, ONES, 64'hABCD_0000_0000_FFFF};
        logic [63:0] vexp [8] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, ONES, ONES, 64'd100,
                                  MIN64, 64'd0, 64'hFFFF_FFFF_FFFE_0001};
        int          vlat [8] = '{64, 32, 32, 0, 0, 0, 0, 32};
        int          lat;
        logic [63:0] res;
        bit          to;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], va[i], vb[i], lat, res, to);
            tests_run++;
            if (to) begin tests_failed++; $display("FAIL directed_%0d_timeout: no valid_out within 200 cycles", i); end
            tests_run++;
            if (lat != vlat[i]) begin tests_failed++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, vlat[i]); end
            tests_run++;
            if (res !== vexp[i]) begin tests_failed++; $display("FAIL directed_%0d_result: got %h expected %h", i, res, vexp[i]); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] exp_res;
        int          exp_lat;
        int          lat;
        logic [63:0] res;
        bit          to;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = 64'd0;
                1: rb[31:0] = 32'd0;
                2: begin ra = MIN64; rb = ONES; end
                3: begin ra[31:0] = 32'h8000_0000; rb = ONES; end
                4: rb = 64'($urandom_range(1, 9));
                default: ;
            endcase
            exp_res = ref_result(op, ra, rb);
            exp_lat = ref_latency(op, ra, rb);
            do_op(op, ra, rb, lat, res, to);
            tests_run++;
            if (to || lat != exp_lat) begin
                tests_failed++;
                $display("FAIL random_%0d_latency op=%0d: got %0d expected %0d", i, op, lat, exp_lat);
            end
            tests_run++;
            if (res !== exp_res) begin
                tests_failed++;
                $display("FAIL random_%0d_result op=%0d a=%h b=%h: got %h expected %h", i, op, ra, rb, res, exp_res);
            end
        end
    endtask

    // Abort a DIV mid-iteration with flush (use_reset=0) or reset (use_reset=1)
    task automatic test_abort(input bit use_reset);
        bit saw_valid;
        @(negedge clk);
        mduop    = 4'd2;
        a        = 64'd1000;
        b        = 64'd7;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        valid_in = 1'b1;
        if (use_reset) reset = 1'b0; else flush = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        flush    = 1'b0;
        valid_in = 1'b0;
        tests_run++;
        if (ready_in !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort%0d_idle: got ready_in=%b busy=%b expected 1 0", use_reset, ready_in, busy);
        end
        if (use_reset) begin
            tests_run++;
            if (result !== 64'd0) begin tests_failed++; $display("FAIL abort_reset_result: got %h expected 0", result); end
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (valid_out) saw_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (saw_valid) begin tests_failed++; $display("FAIL abort%0d_no_valid: got valid_out pulse expected none", use_reset); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] exp_res;
        logic [63:0] r0;
        int          k;
        bit          ok;
        ra      = {$urandom, $urandom};
        rb      = {$urandom, $urandom};
        exp_res = ref_result(4'd1, ra, rb);
        @(negedge clk);
        mduop    = 4'd1;
        a        = ra;
        b        = rb;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        k = 0;
        while (!valid_out && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        tests_run++;
        if (!valid_out || result !== exp_res) begin
            tests_failed++;
            $display("FAIL bp_result: got %h valid=%b expected %h", result, valid_out, exp_res);
        end
        r0 = result;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (result !== r0 || ready_in !== 1'b0 || valid_out !== 1'b1) ok = 1'b0;
        end
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL bp_hold: got result=%h ready_in=%b valid_out=%b expected %h 0 1", result, ready_in, valid_out, r0); end
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        tests_run++;
        if (valid_out !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_consume: got valid_out=%b busy=%b expected 0 0", valid_out, busy);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_second_accept: got busy=%b expected 1", busy); end
        valid_in = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        flush        = 1'b0;
        valid_in     = 1'b0;
        ready_out    = 1'b0;
        mduop        = 4'd0;
        a            = 64'd0;
        b            = 64'd0;
        test_reset();
        test_directed();
        test_random();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameters: none; operand/result width SHALL be fixed at 64 bits.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-003 reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 flush  in  1  pipeline flush; abandons any accepted or in-flight operation.
REQ-005 valid_in  in  1  request valid from the execute stage.
REQ-006 ready_in  out  1  block can accept a request this cycle.
REQ-007 mduop  in  4  mdu_op_t encoding: NOP=0, MUL=1, DIV=2, DIVU=3, REM=4, REMU=5, MULW=6, DIVW=7, DIVUW=8, REMW=9, REMUW=10; 11-15 reserved.
REQ-008 a  in  64  operand rs1 value (multiplicand/dividend).
REQ-009 b  in  64  operand rs2 value (multiplier/divisor).
REQ-010 valid_out  out  1  result valid.
REQ-011 ready_out  in  1  consumer accepts result.
REQ-012 result  out  64  operation result.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE, BUSY, DONE; ready_in SHALL equal (state==IDLE); valid_out SHALL equal (state==DONE).
REQ-015 Accept: valid_in && ready_in && !flush at an edge; a, b and mduop SHALL be latched, so inputs may change afterwards.
REQ-016 IDLE->BUSY on accept for MUL, MULW, DIV*, REM* with no special case; iteration counter SHALL load N=64 (64-bit ops) or N=32 (W ops).
REQ-017 BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements; BUSY->DONE at the edge where the counter reaches 0, i.e. valid_out rises exactly N cycles after the accept edge.
REQ-018 Special cases SHALL bypass BUSY (IDLE->DONE at the accept edge, valid_out the next cycle): NOP and reserved codes (result 0), divisor zero, signed overflow.
REQ-019 DONE->IDLE at the edge where ready_out is high; result SHALL hold stable while valid_out && !ready_out.
REQ-020 Accepting a new request in the same cycle a DONE result is consumed is not required; ready_in stays low in DONE.
REQ-021 MUL: low 64 bits of a*b. MULW: low 32 bits of a[31:0]*b[31:0], sign-extended to 64.
REQ-022 DIV/REM: signed, quotient truncated toward zero, remainder takes sign of dividend. DIVU/REMU: unsigned.
REQ-023 W divides use a[31:0], b[31:0] (signed for DIVW/REMW, unsigned for DIVUW/REMUW); the 32-bit result SHALL be sign-extended to 64 for all four.
REQ-024 Divisor zero: DIV/DIVU/DIVW/DIVUW result all ones (0xFFFF_FFFF_FFFF_FFFF); REM/REMU result a; REMW/REMUW result a[31:0] sign-extended.
REQ-025 Overflow: DIV a=0x8000_0000_0000_0000, b=-1 -> a; REM -> 0; DIVW a[31:0]=0x8000_0000, b[31:0]=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000; REMW -> 0.
REQ-026 flush high at an edge SHALL force IDLE from any state, discard the operation, and block acceptance that edge (flush wins over valid_in).
REQ-027 No combinational path from valid_in, a, b or mduop to valid_out or result.

Reset
REQ-028 reset low at an edge SHALL force IDLE and counter 0, overriding flush and valid_in.
REQ-029 After reset: ready_in=1, valid_out=0, busy=0, result=0.
REQ-030 Reset mid-operation SHALL discard the operation; no valid_out pulse follows.

Verification
REQ-031 MUL a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> valid_out 64 cycles after accept, result 0xFFFF_FFFF_FFFF_FFFE; held until ready_out.
REQ-032 DIVW a=0x0000_0000_FFFF_FFF9 (-7), b=2 -> 32 cycles, result 0xFFFF_FFFF_FFFF_FFFD; REMW same operands -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-033 DIVU a=100, b=0 -> valid_out 1 cycle after accept, result all ones; REMU -> 100.
REQ-034 DIV a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> 1 cycle, result 0x8000_0000_0000_0000; REM -> 0.
REQ-035 Accept DIV, assert flush at cycle 10 of BUSY -> IDLE next cycle, ready_in=1, no valid_out; repeat with reset low -> same, result=0.
REQ-036 Backpressure: hold ready_out=0 for 5 cycles in DONE with valid_in=1 -> result stable, ready_in=0, no second accept until the cycle after consumption.
